// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port with
// same-cycle write-through bypass, and a per-register pending-write scoreboard.
// Latency: reads are combinational; writes, claims and clears land on the next
// posedge. Backpressure: none. Writes, claims and clr_start presented while the
// clear engine is active are dropped, not queued.
//
// Ports:
//   clk, rst                  clock (posedge) and asynchronous active-high reset
//   we, wa, wd                write port (entry[wa] <= wd, pending[wa] <= 0)
//   ra1/rd1, ra2/rd2          combinational read ports with write bypass
//   pc_in                     value returned when the PC-mapped register is read
//   claim, claim_addr         mark a register as having an in-flight producer
//   busy1, busy2              pending bit for ra1 / ra2
//   clr_start                 start the sequential clear sweep
//   clr_busy, clr_done        sweep in progress / one-cycle completion pulse

module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1,
   parameter int PC_REG   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [DATA_W-1:0] rd1,
   output logic [DATA_W-1:0] rd2,
   input  logic [DATA_W-1:0] pc_in,
   input  logic              claim,
   input  logic [ADDR_W-1:0] claim_addr,
   output logic              busy1,
   output logic              busy2,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int                NREG      = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

   // Clear engine states
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLEAR = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   pend_q;
   logic [NREG-1:0]   pend_d;
   logic [1:0]        state_q;
   logic [1:0]        state_d;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_d;

   logic              idle;
   logic              wr_en;
   logic              claim_en;
   logic              bypass_en;

   // Address 0 (zero register) and/or NREG-1 (PC register) are hard-wired:
   // they never hold written data and are never marked pending.
   function automatic logic is_rsvd(input logic [ADDR_W-1:0] a);
      return ((ZERO_REG != 0) && (a == '0)) ||
             ((PC_REG != 0) && (a == LAST_ADDR));
   endfunction

   // Read mux shared by both ports. Hard-wired registers take priority over
   // the bypass so a dropped write to them is never visible, even in the same
   // cycle.
   function automatic logic [DATA_W-1:0] read_mux(
      input logic [ADDR_W-1:0] ra,
      input logic [DATA_W-1:0] stored
   );
      logic [DATA_W-1:0] val;
      val = stored;
      if ((ZERO_REG != 0) && (ra == '0)) begin
         val = '0;
      end else if ((PC_REG != 0) && (ra == LAST_ADDR)) begin
         val = pc_in;
      end else if (bypass_en && (wa == ra)) begin
         val = wd;
      end
      return val;
   endfunction

   assign idle      = (state_q == S_IDLE);
   // Writes and claims are only honoured while the clear engine is idle;
   // during the sweep they are dropped so the file ends up fully zeroed.
   assign bypass_en = we && idle;
   assign wr_en     = we && idle && !is_rsvd(wa);
   assign claim_en  = claim && idle && !is_rsvd(claim_addr);

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
   always_comb begin
      rd1 = read_mux(ra1, regs_q[ra1]);
      rd2 = read_mux(ra2, regs_q[ra2]);
   end

   // No bypass on busy: a same-cycle write does not hide the pending bit
   // until it has actually landed.
   always_comb begin
      busy1 = is_rsvd(ra1) ? 1'b0 : pend_q[ra1];
      busy2 = is_rsvd(ra2) ? 1'b0 : pend_q[ra2];
   end

   assign clr_busy = (state_q == S_CLEAR);
   assign clr_done = (state_q == S_DONE);

   // ------------------------------------------------------------------
   // Clear engine
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (clr_start) begin
               state_d = S_CLEAR;
               idx_d   = '0;
            end
         end
         S_CLEAR: begin
            // idx stops at the last entry instead of wrapping
            if (idx_q == LAST_ADDR) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Storage and scoreboard next-state
   // ------------------------------------------------------------------
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (wr_en) begin
         regs_d[wa] = wd;
         pend_d[wa] = 1'b0;
      end
      // Applied after the write so that a same-cycle claim of the written
      // register leaves it pending: the claimer is a newer producer.
      if (claim_en) begin
         pend_d[claim_addr] = 1'b1;
      end
      // Sweep writes one entry per cycle; reserved entries are cleared too,
      // which is harmless since they are never read from storage.
      if (state_q == S_CLEAR) begin
         regs_d[idx_q] = '0;
         pend_d[idx_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         pend_q  <= '0;
         state_q <= S_IDLE;
         idx_q   <= '0;
      end else begin
         regs_q  <= regs_d;
         pend_q  <= pend_d;
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

endmodule
